// File: rtl/timer_irq_unit.sv
// rtl/timer_irq_unit.sv - memory-mapped reload timer with overflow interrupt and free-running cycle counter
module timer_irq_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    // Register word indices within the block (Addr[3:2]).
    localparam logic [1:0] REG_TH      = 2'd0;
    localparam logic [1:0] REG_TL      = 2'd1;
    localparam logic [1:0] REG_TCON    = 2'd2;
    localparam logic [1:0] REG_SYSTICK = 2'd3;

    // Last prescaler count before a tick; PRESCALE is limited to 1..65535.
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        st_q, st_d;
    logic [31:0] systick_q, systick_d;
    logic [15:0] pre_q, pre_d;
    logic        irq_q, irq_d;

    logic        hit;
    logic [1:0]  sel;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        tick;
    logic        ovf;

    // Address decode: a hit needs the block's upper address bits and word alignment.
    always_comb begin
        hit     = (Addr[31:4] == BASE_ADDR[31:4]) && (Addr[1:0] == 2'b00);
        sel     = Addr[3:2];
        wr_th   = MemWr && hit && (sel == REG_TH);
        wr_tl   = MemWr && hit && (sel == REG_TL);
        wr_tcon = MemWr && hit && (sel == REG_TCON);
    end

    // Prescaler: ticks on the last count while enabled, held at zero once counting stops.
    always_comb begin
        tick  = en_q && (pre_q == PRE_LAST);
        pre_d = 16'd0;
        if (en_q && en_d && !tick) begin
            pre_d = pre_q + 16'd1;
        end
    end

    // Counter, reload and control bits; a bus write to TL beats the tick, overflow always sets ST.
    always_comb begin
        ovf  = tick && (tl_q == 32'hFFFF_FFFF);
        th_d = th_q;
        tl_d = tl_q;
        en_d = en_q;
        ie_d = ie_q;
        st_d = st_q;
        if (tick) begin
            tl_d = ovf ? th_q : (tl_q + 32'd1);
        end
        if (wr_th) begin
            th_d = WriteData;
        end
        if (wr_tl) begin
            tl_d = WriteData;
        end
        if (wr_tcon) begin
            en_d = WriteData[0];
            ie_d = WriteData[1];
            st_d = WriteData[2];
        end
        if (ovf) begin
            st_d = 1'b1;
        end
    end

    // Free-running cycle counter and the registered interrupt request.
    always_comb begin
        systick_d = systick_q + 32'd1;
        irq_d     = ie_q && st_q;
    end

    // Combinational read mux showing pre-edge register values.
    always_comb begin
        ReadData = 32'h0;
        if (MemRd && hit) begin
            unique case (sel)
                REG_TH:      ReadData = th_q;
                REG_TL:      ReadData = tl_q;
                REG_TCON:    ReadData = {29'h0, st_q, ie_q, en_q};
                REG_SYSTICK: ReadData = systick_q;
                default:     ReadData = 32'h0;
            endcase
        end
    end

    assign IRQ = irq_q;

    // State registers with synchronous reset taking priority over all updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= 32'h0;
            tl_q      <= 32'h0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            st_q      <= 1'b0;
            systick_q <= 32'h0;
            pre_q     <= 16'h0;
            irq_q     <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            st_q      <= st_d;
            systick_q <= systick_d;
            pre_q     <= pre_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: doc/timer_irq_unit.md
Name: timer_irq_unit

Overview:
- Memory-mapped timer peripheral that raises the level-sensitive IRQ consumed by the Control decoder.
- Sits on the data-memory bus beside data RAM and is selected by address.
- Software loads a reload value, enables counting, and takes an interrupt on counter overflow.
- The interrupt handler runs in kernel mode (PC31=1) and clears the status bit to drop IRQ.

Parameters:
- BASE_ADDR, 32'h40000000, base byte address of the register block.
- PRESCALE, 1, clock cycles per timer tick; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRd  input  1  bus read strobe from Control.
- MemWr  input  1  bus write strobe from Control.
- Addr  input  32  byte address (ALU result).
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational.
- IRQ  output  1  interrupt request to Control, registered.

Behaviour:
- Register map, word offsets from BASE_ADDR:
  - +0x00 TH: reload value, R/W.
  - +0x04 TL: counter, R/W.
  - +0x08 TCON, R/W, bits [2:0]; upper bits read 0. [0]=EN count enable, [1]=IE interrupt enable, [2]=ST overflow status.
  - +0x0C SYSTICK: free-running 32-bit cycle counter, read-only; writes ignored.
- Address decoding:
  - Hit requires Addr[31:4]==BASE_ADDR[31:4] and Addr[1:0]==0.
  - Any other address: no state change, ReadData=0.
- Reset (reset=1 at a rising edge): TH=0, TL=0, TCON=0, SYSTICK=0, prescaler count=0, IRQ=0. Reset wins over every other event in the same cycle.
- Read path:
  - ReadData = selected register when MemRd=1 and the address hits; otherwise 32'h0.
  - Zero-latency combinational read; reflects pre-edge values.
- Write path: when MemWr=1 and the address hits, the register updates at the rising edge; the new value is visible the next cycle.
- Prescaler:
  - Counts only while EN=1; held at 0 while EN=0.
  - Asserts an internal tick when count==PRESCALE-1, then wraps to 0. With PRESCALE=1, a tick occurs every cycle while EN=1.
- Counter on tick:
  - If TL==32'hFFFFFFFF: TL<=TH and ST<=1 (overflow).
  - Otherwise: TL<=TL+1.
- SYSTICK increments every cycle regardless of EN and wraps 32'hFFFFFFFF->0.
- IRQ is the registered value of IE&ST: IRQ goes high 1 cycle after the edge that sets ST, given IE=1. It stays high until ST or IE is cleared.
- Simultaneous events:
  - Write to TL in the same cycle as a tick or overflow: the written value wins, and ST still sets if an overflow occurred.
  - Write to TH in the same cycle as an overflow: TL reloads with the old TH.
  - Write to TCON with bit2=0 in the same cycle as an overflow: ST=1 (set wins); EN and IE take the written values.
  - Write to TCON setting EN=0 in the same cycle as a tick: the tick still applies that cycle.
- MemRd and MemWr both high: the write is performed and the read returns the pre-write value.
- The unit does not see PC31; kernel-mode masking is done in Control.

Test Plan:
- Reset then read: assert reset 2 cycles; read TH, TL, TCON, SYSTICK -> all 0, IRQ=0; read 0x40000010 -> 0.
- Overflow and IRQ, PRESCALE=1: write TH=FFFFFFFC, TL=FFFFFFFE, TCON=3. Expected sequence:
  - Tick 1: TL=FFFFFFFF.
  - Tick 2: TL=FFFFFFFC, ST=1.
  - IRQ=1 one cycle later.
  - TCON reads 7.
- IRQ clear: while IRQ=1, write TCON=3 -> ST=0, IRQ=0 next cycle; counting continues FFFFFFFC, FFFFFFFD, ...
- Set-wins collision: arrange overflow on the same edge as a write of TCON=3 -> TCON reads 7, IRQ stays 1.
- Prescaler and masking, PRESCALE=4: TH=0, TL=FFFFFFFE, TCON=1 (IE=0) -> TL changes every 4th cycle; after 8 cycles ST=1 but IRQ remains 0; then write TCON=7 -> IRQ=1 next cycle.
- Bus and SYSTICK: write SYSTICK=1234 -> ignored, keeps counting; MemRd=0 with a valid Addr -> ReadData=0; misaligned Addr 0x40000006 write -> no register changes.
